decoder_scan: RTL and testbench

//   Parametrised, registered binary-to-one-hot decoder with an auto-scan mode.
//   - Direct mode: decodes a W-bit code to a 2**W one-hot output, one cycle of latency.
//   - Scan mode: sweeps the active output 0..scan_last, holding each for DWELL cycles.
//   - Used as a multiplexed display/row driver and as a general select-line generator.

---
 rtl/decoder_scan.sv | 78 +++++++
 tb/tb_decoder_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with an auto-scan mode that sweeps the
// active output from 0 to scan_last, holding each index for DWELL cycles.
module decoder_scan #(
  parameter int unsigned W     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [W-1:0]      in,
  input  logic [W-1:0]      scan_last,
  output logic [2**W-1:0]   d,
  output logic [W-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned N  = 2**W;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DwellMax = DW'(DWELL - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDirect = 2'd1;
  localparam logic [1:0] StScan   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  idx_d;
  logic          wrap_d;
  logic [N-1:0]  d_d;

  always_comb begin
    state_d = state_q;
    dwell_d = '0;
    idx_d   = idx;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else if (!mode) begin
      state_d = StDirect;
      idx_d   = in;
    end else if (state_q != StScan) begin
      // Entry into scan always restarts the sweep at index 0 without a wrap pulse.
      state_d = StScan;
      idx_d   = '0;
    end else begin
      state_d = StScan;
      if (dwell_q == DwellMax) begin
        if (idx >= scan_last) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx + 1'b1;
        end
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    d_d = (state_d == StIdle) ? '0 : ({{(N-1){1'b0}}, 1'b1} << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dwell_q <= '0;
      idx     <= '0;
      wrap    <= 1'b0;
      d       <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      idx     <= idx_d;
      wrap    <= wrap_d;
      d       <= d_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: explicit vector table, directed corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] in, scan_last;
  logic [7:0] d0, d1;
  logic [2:0] idx0, idx1;
  logic       wrap0, wrap1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_scan #(.W(3), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in), .scan_last(scan_last),
    .d(d0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan #(.W(3), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in), .scan_last(scan_last),
    .d(d1), .idx(idx1), .wrap(wrap1)
  );

  // Model: on/scan flags, active index, and cycles already spent on that index.
  typedef struct {
    bit on;
    bit scan;
    int idx;
    int age;
    bit wrap;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mstep(mdl_t m, bit r, bit e, bit md, int code, int last, int dwell);
    mdl_t n = m;
    n.wrap = 1'b0;
    if (r) begin
      n.on = 0; n.scan = 0; n.idx = 0; n.age = 0;
    end else if (!e) begin
      n.on = 0; n.scan = 0; n.age = 0;
    end else if (!md) begin
      n.on = 1; n.scan = 0; n.idx = code; n.age = 0;
    end else if (!(m.on && m.scan)) begin
      n.on = 1; n.scan = 1; n.idx = 0; n.age = 0;
    end else begin
      n.age = m.age + 1;
      if (n.age == dwell) begin
        n.age = 0;
        if (m.idx >= last) begin
          n.idx  = 0;
          n.wrap = 1;
        end else begin
          n.idx = m.idx + 1;
        end
      end
    end
    return n;
  endfunction

  function automatic int exp_d(mdl_t m);
    return m.on ? (1 << m.idx) : 0;
  endfunction

  task automatic check(string name, int act, int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: advance both models, then compare both DUTs against them.
  task automatic step();
    @(posedge clk);
    m0 = mstep(m0, rst, en, mode, int'(in), int'(scan_last), 4);
    m1 = mstep(m1, rst, en, mode, int'(in), int'(scan_last), 1);
    #1;
    vectors++;
    check("model_d",     int'(d0),    exp_d(m0));
    check("model_idx",   int'(idx0),  m0.idx);
    check("model_wrap",  int'(wrap0), int'(m0.wrap));
    check("model1_d",    int'(d1),    exp_d(m1));
    check("model1_idx",  int'(idx1),  m1.idx);
    check("model1_wrap", int'(wrap1), int'(m1.wrap));
  endtask

  typedef struct {
    bit       r, e, md;
    bit [2:0] code, last;
    bit [7:0] xd;
    bit [2:0] xidx;
    bit       xwrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit r, bit e, bit md, bit [2:0] code, bit [2:0] last,
                     bit [7:0] xd, bit [2:0] xidx, bit xwrap);
    vec_t v;
    v.r = r; v.e = e; v.md = md; v.code = code; v.last = last;
    v.xd = xd; v.xidx = xidx; v.xwrap = xwrap;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int max_idx;
    bit seen;
    m0 = '{0, 0, 0, 0, 0};
    m1 = '{0, 0, 0, 0, 0};
    rst = 1; en = 1; mode = 1; in = 0; scan_last = 0;

    // Reset held with scan requested, release into idle, direct decode, scan sweep.
    add(1, 1, 1, 0, 2, 8'h00, 0, 0);
    add(1, 1, 1, 0, 2, 8'h00, 0, 0);
    add(0, 0, 1, 0, 2, 8'h00, 0, 0);
    add(0, 1, 0, 5, 2, 8'h20, 5, 0);
    add(0, 1, 0, 0, 2, 8'h01, 0, 0);
    add(0, 0, 0, 0, 2, 8'h00, 0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) add(0, 1, 1, 0, 2, 8'h01, 0, (k == 1 && c == 0));
      for (int c = 0; c < 4; c++) add(0, 1, 1, 0, 2, 8'h02, 1, 0);
      for (int c = 0; c < 4; c++) add(0, 1, 1, 0, 2, 8'h04, 2, 0);
    end
    add(0, 1, 1, 0, 2, 8'h01, 0, 1);
    add(0, 1, 1, 0, 2, 8'h01, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; en = tbl[i].e; mode = tbl[i].md;
      in = tbl[i].code; scan_last = tbl[i].last;
      step();
      check($sformatf("tbl%0d_d", i),    int'(d0),    int'(tbl[i].xd));
      check($sformatf("tbl%0d_idx", i),  int'(idx0),  int'(tbl[i].xidx));
      check($sformatf("tbl%0d_wrap", i), int'(wrap0), int'(tbl[i].xwrap));
    end

    // Lower scan_last below the active index: wrap at next boundary, sweep stops at 3.
    en = 0; step();
    en = 1; mode = 1; scan_last = 7;
    n = 0;
    do begin step(); n++; end while (!(m0.idx == 6 && m0.age == 1) && n < 100);
    check("reach_idx6", int'(idx0), 6);
    scan_last = 3;
    n = 0; seen = 0;
    while (!seen && n < 8) begin
      step(); n++;
      if (wrap0) seen = 1;
    end
    check("lower_last_wrap", int'(seen), 1);
    check("lower_last_idx", int'(idx0), 0);
    max_idx = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (int'(idx0) > max_idx) max_idx = int'(idx0);
    end
    check("lower_last_max", max_idx, 3);

    // Reset mid-scan at idx 4, dwell 2; restart holds index 0 for a full dwell.
    scan_last = 7;
    n = 0;
    do begin step(); n++; end while (!(m0.idx == 4 && m0.age == 2) && n < 100);
    check("reach_idx4", int'(idx0), 4);
    rst = 1; step();
    check("midscan_rst_d", int'(d0), 0);
    check("midscan_rst_idx", int'(idx0), 0);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("restart_d", int'(d0), 1);
    end
    step();
    check("restart_adv_d", int'(d0), 2);

    // DWELL=1 with scan_last=0: index 0 constant, wrap every cycle after entry.
    en = 0; step();
    en = 1; mode = 1; scan_last = 0;
    step();
    check("dw1_entry_d", int'(d1), 1);
    check("dw1_entry_wrap", int'(wrap1), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("dw1_d", int'(d1), 1);
      check("dw1_wrap", int'(wrap1), 1);
    end
    mode = 0; in = 3;
    step();
    check("dw1_direct_d", int'(d1), 8'h08);
    check("dw1_direct_wrap", int'(wrap1), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(99) == 0);
      en = ($urandom_range(19) != 0);
      if ($urandom_range(29) == 0) mode = ~mode;
      in = 3'($urandom);
      if ($urandom_range(15) == 0) scan_last = 3'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
